// File: rtl/disp_pkg.sv
// Shared types and sizing helpers for the display scheduler slice.
package disp_pkg;

   typedef enum logic {IDLE, SHOW} disp_state_e;

   localparam int DWELL_W = 16;

   function automatic int calc_div(input int clk_hz, input int scan_hz);
      return clk_hz / scan_hz;
   endfunction

   function automatic int calc_pre_w(input int clk_hz, input int scan_hz);
      int d;
      d = clk_hz / scan_hz;
      return (d <= 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Source-side request bus and driver-side display outputs of display_scheduler.
interface display_scheduler_if #(parameter int NUM_SRC = 4) ();

   logic [NUM_SRC-1:0]       src_req;
   logic [NUM_SRC-1:0][15:0] src_value;
   logic [NUM_SRC-1:0]       src_grant;
   logic                     scan_tick;
   logic                     frame_start;
   logic [15:0]              disp_number;
   logic                     disp_enable;

   modport master (output src_req, src_value,
                   input  src_grant, scan_tick, frame_start, disp_number, disp_enable);
   modport slave  (input  src_req, src_value,
                   output src_grant, scan_tick, frame_start, disp_number, disp_enable);

endinterface

// File: rtl/disp_tick_gen.sv
// Scan prescaler and 2-bit digit phase; scan_tick every DIV cycles, frame_start on the 3->0 wrap.
module disp_tick_gen
   import disp_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic scan_tick,
   output logic frame_start
);

   localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
   localparam int PW  = calc_pre_w(CLK_HZ, SCAN_HZ);

   logic [PW-1:0] pre_cnt;
   logic [1:0]    phase;
   logic          wrap;

   assign wrap = (pre_cnt == PW'(DIV - 1));

   // Pulses are registered so they are glitch-free and 0 out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt     <= '0;
         phase       <= '0;
         scan_tick   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pre_cnt     <= wrap ? '0 : pre_cnt + 1'b1;
         scan_tick   <= wrap;
         frame_start <= wrap && (phase == 2'd3);
         if (wrap) phase <= phase + 2'd1;
      end
   end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the 4-digit display with frame-aligned grant/value updates.
// Optional DISP_SCHED_FREEZE_EN adds a freeze input that holds the arbitration state.
module display_scheduler
   import disp_pkg::*;
#(
   parameter int NUM_SRC  = 4,
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int DWELL_MS = 500
) (
   input  logic clk,
   input  logic reset,
   display_scheduler_if.slave bus
`ifdef DISP_SCHED_FREEZE_EN
   , input logic freeze
`endif
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic scan_tick, frame_start, frz;

   disp_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (
      .clk         (clk),
      .reset       (reset),
      .scan_tick   (scan_tick),
      .frame_start (frame_start)
   );

`ifdef DISP_SCHED_FREEZE_EN
   assign frz = freeze;
`else
   assign frz = 1'b0;
`endif

   disp_state_e          state_q, state_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d, pick_idx;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [15:0]          num_q, num_d;
   logic                 en_q, en_d, pick_vld, others;
   logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_inc;

   // Search starts just after the last granted index, so the current owner is checked last.
   always_comb begin
      logic [IDX_W-1:0] cand;
      pick_vld = 1'b0;
      pick_idx = gidx_q;
      cand     = gidx_q;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = IDX_W'((int'(gidx_q) + k) % NUM_SRC);
         if (!pick_vld && bus.src_req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign others    = |(bus.src_req & ~grant_q);
   assign dwell_inc = (dwell_q >= DWELL_W'(DWELL_MS)) ? dwell_q : dwell_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gidx_q  <= IDX_W'(NUM_SRC - 1);
         grant_q <= '0;
         num_q   <= '0;
         en_q    <= 1'b0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         num_q   <= num_d;
         en_q    <= en_d;
         dwell_q <= dwell_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      num_d   = num_q;
      en_d    = en_q;
      dwell_d = dwell_q;
      if (scan_tick && state_q == SHOW) dwell_d = dwell_inc;
      if (frame_start && frz) begin
         dwell_d = dwell_q;
      end else if (frame_start) begin
         // dwell_inc already counts the tick that closes this frame.
         if ((state_q == IDLE) ||
             !bus.src_req[gidx_q] ||
             (others && dwell_inc >= DWELL_W'(DWELL_MS))) begin
            if (pick_vld) begin
               state_d = SHOW;
               gidx_d  = pick_idx;
               grant_d = NUM_SRC'(1) << pick_idx;
               num_d   = bus.src_value[pick_idx];
               en_d    = 1'b1;
               dwell_d = '0;
            end else begin
               state_d = IDLE;
               grant_d = '0;
               en_d    = 1'b0;
            end
         end else begin
            num_d = bus.src_value[gidx_q];
         end
      end
   end

   assign bus.src_grant   = grant_q;
   assign bus.disp_number = num_q;
   assign bus.disp_enable = en_q;
   assign bus.scan_tick   = scan_tick;
   assign bus.frame_start = frame_start;

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 4-digit seven-segment display between up to NUM_SRC requesters and generates its scan timing. The block sits between the CPU/debug sources and the existing display driver: it drives the driver's scan enable, DisplayEnable and 16-bit Number inputs. Grant changes and value updates happen only at scan-frame boundaries, so a digit frame never mixes two values.

## Interface
- NUM_SRC, 4: number of requesters, 2..8
- CLK_HZ, 100_000_000: system clock frequency
- SCAN_HZ, 1000: digit scan rate, one digit per tick
- DWELL_MS, 500: minimum scan ticks a granted source is shown while others wait, ≥1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- src_req  in  NUM_SRC  per-source request to be displayed; level, held while wanted
- src_value  in  16*NUM_SRC  source i value on bits [16i+15:16i]
- src_grant  out  NUM_SRC  one-hot currently displayed source, 0 when idle
- scan_tick  out  1  one-cycle pulse every DIV = CLK_HZ/SCAN_HZ cycles; replaces clk_1K as the driver's scan enable
- frame_start  out  1  pulse coincident with scan_tick when scan phase wraps 3→0
- disp_number  out  16  value for the driver
- disp_enable  out  1  driver DisplayEnable
- freeze  in  1  present only with DISP_SCHED_FREEZE_EN

## Operation
- Prescaler: counter 0..DIV-1; scan_tick=1 when count==DIV-1, then count wraps to 0.
- Scan phase: 2-bit counter, increments on scan_tick; frame_start=scan_tick && phase==3.
- FSM states: IDLE, SHOW. All state/grant/value updates occur only on frame_start.
- IDLE: src_grant=0, disp_enable=0, disp_number holds its last value. On frame_start with any src_req: grant the first requester found by round-robin search starting at last_grant+1 (last_grant=NUM_SRC-1 after reset, so source 0 searches first); latch its src_value into disp_number; dwell:=0; go to SHOW.
- SHOW: disp_enable=1. dwell increments on every scan_tick and saturates at DWELL_MS. On each frame_start:
  - granted source's req low: round-robin re-arbitrate immediately, ignoring dwell; if no requester, go to IDLE.
  - req high, another source requesting, dwell ≥ DWELL_MS: grant the next requester in round-robin order, dwell:=0.
  - otherwise: keep grant; disp_number:=current src_value of the granted source, so live values are tracked once per frame.
- Only one grant at a time; src_grant is always one-hot or zero.
- Reset mid-operation: all counters, FSM and outputs return to reset values on the next edge. No partial frame completes.

## Timing
- Reset values: scan_tick=0, frame_start=0, src_grant=0, disp_number=0, disp_enable=0, prescaler=0, phase=0, dwell=0, state=IDLE.
- First scan_tick occurs DIV cycles after the first edge with reset low. The first frame_start is the 4th scan_tick.
- Request-to-display latency: src_grant, disp_number and disp_enable are registered and change on the edge following frame_start. Worst case is 4·DIV+1 cycles.
- Value latency while shown is at most one frame (4·DIV cycles).
- A requester dropping and re-asserting within one frame is invisible.

## Configuration
- DISP_SCHED_FREEZE_EN defined: the freeze port exists. While freeze=1 at frame_start, state, grant, dwell and disp_number hold. Prescaler, phase, scan_tick and frame_start keep running.
- Not defined: no freeze port; behaviour is identical to freeze tied to 0.

## Structure
- Shared package disp_pkg holds:
  - the state typedef (IDLE, SHOW);
  - a function computing DIV and the prescaler width from CLK_HZ/SCAN_HZ;
  - the DWELL counter width constant.
- Sub-module disp_tick_gen: prescaler plus phase counter, producing scan_tick and frame_start.
- Arbitration and FSM live in display_scheduler.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10), NUM_SRC=4, DWELL_MS=8.
- Reset release, no requests -> scan_tick at cycles 10, 20, 30, 40; frame_start only at cycle 40; disp_enable and src_grant stay 0.
- src_req=0001, value0=16'h1234 before cycle 40 -> src_grant=0001, disp_number=16'h1234, disp_enable=1 one cycle after frame_start.
- Source 0 shown, src_req=0101 constantly -> grant alternates 0001↔0100, switching at the first frame_start with dwell ≥ 8 (every 2 frames).
- Shown source 2 drops req mid-frame while source 3 requests -> at the next frame_start grant becomes 1000, regardless of dwell.
- value0 changes 16'hABCD→16'h00FF mid-frame -> disp_number changes only after the next frame_start.
- DISP_SCHED_FREEZE_EN: freeze=1 across 3 frames with competing requests -> grant and disp_number unchanged while scan_tick keeps pulsing. Reset asserted mid-frame -> all outputs 0 on the next edge.
